// File: rtl/fifo_rd_arbiter.sv
// Read-side arbiter that shares one async-FIFO read port among NREQ consumers,
// issuing bounded bursts of pops. Define ARB_FIXED_PRIO_EN for fixed priority.
module fifo_rd_arbiter #(
  parameter int NREQ     = 4,
  parameter int DSIZE    = 8,
  parameter int MAXBURST = 4
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [NREQ-1:0]  req,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic [NREQ-1:0]  gnt,
  output logic [DSIZE-1:0] dout,
  output logic             dout_vld,
  output logic             busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAXBURST) + 1;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t          r_state;
  logic [NREQ-1:0] r_gnt;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   r_last;
  logic [BW-1:0]   r_bcnt;

  logic            w_win_vld;
  logic [IW-1:0]   w_win;
  logic            w_pop;
  logic            w_last_pop;
  logic            w_release;

  // Loops run from lowest to highest priority so the final hit is the winner.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_win_vld = 1'b0;
    w_win     = '0;
`ifdef ARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        w_win_vld = 1'b1;
        w_win     = IW'(i);
      end
    end
`else
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(r_last) + k) % NREQ;
      if (req[idx]) begin
        w_win_vld = 1'b1;
        w_win     = IW'(idx);
      end
    end
`endif
  end

  assign w_pop      = (r_state == ST_GRANT) && req[r_owner] && !rempty;
  assign w_last_pop = w_pop && (r_bcnt == BW'(MAXBURST - 1));
  // A dropped request releases without popping; an empty FIFO just stalls.
  assign w_release  = (r_state == ST_GRANT) && (w_last_pop || !req[r_owner]);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_owner <= '0;
      r_last  <= IW'(NREQ - 1);
      r_bcnt  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      case (r_state)
        ST_IDLE: begin
          if (w_win_vld && !rempty) begin
            r_gnt   <= NREQ'(1) << w_win;
            r_owner <= w_win;
            r_bcnt  <= '0;
            r_state <= ST_GRANT;
          end else begin
            r_gnt   <= '0;
          end
        end
        ST_GRANT: begin
          if (w_pop) begin
            r_bcnt <= r_bcnt + 1'b1;
          end
          if (w_release) begin
            r_gnt   <= '0;
            r_last  <= r_owner;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
        end
      endcase
    end
  end

  assign rinc     = w_pop;
  assign dout_vld = w_pop;
  assign dout     = rdata;
  assign gnt      = r_gnt;
  assign busy     = (r_state == ST_GRANT);

endmodule
